// File: rtl/jb_dfe_time_delay_pkg.sv
// Shared widths, state enum and clamp helper
// for the DFE antenna time-delay controller.
package jb_dfe_time_delay_pkg;

  localparam int INT_W = 7;
  localparam int FRT_W = 16;

  typedef logic signed [INT_W-1:0] td_int_t;
  typedef logic signed [FRT_W-1:0] td_frt_t;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    TRIG,
    HOLD
  } td_state_e;

  // Saturate a requested integer delay to 0..max_v.
  function automatic td_int_t clamp_int(
    input td_int_t v,
    input int      max_v
  );
    if (v < 0)
      return '0;
    if (int'(v) > max_v)
      return td_int_t'(max_v);
    return v;
  endfunction

endpackage

// File: rtl/jb_dfe_td_pulse_timer.sv
// Down-counter timing the TRIG pulse and HOLD settle.
// Ports: clk_1x, rst, load/load_val (preset),
// count (decrement enable), done (counter at zero).
module jb_dfe_td_pulse_timer #(
  parameter int W = 4
) (
  input  logic         clk_1x,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         count,
  output logic         done
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk_1x or posedge rst) begin
    if (rst)
      cnt_q <= '0;
    else if (load)
      cnt_q <= load_val;
    else if (count && cnt_q != '0)
      cnt_q <= cnt_q - 1'b1;
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/jb_dfe_time_delay_ctrl.sv
// Antenna time-delay update controller: shadow -> target
// on commit, target -> outputs on frame_strb, then a
// TRIG pulse and HOLD settle (IDLE/ARMED/TRIG/HOLD).
// Ports: clk_1x, rst; write wr_en/wr_ant/wr_int/wr_frt;
// commit, frame_strb, err_clr; outputs int_delay[],
// frt_delay[], time_reg_trigger, busy, range_err.
// JB_DFE_TD_STEP_LIMIT_EN: int_delay moves at most
// MAX_STEP per TRIG; frt follows once int arrives.
module jb_dfe_time_delay_ctrl
  import jb_dfe_time_delay_pkg::*;
#(
  parameter int N_ANTENNAS = 4,
  parameter int TRIG_LEN   = 4,
  parameter int HOLD_LEN   = 16,
  parameter int INT_MAX    = 63
`ifdef JB_DFE_TD_STEP_LIMIT_EN
  ,
  parameter int MAX_STEP   = 4
`endif
) (
  input  logic                          clk_1x,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic [$clog2(N_ANTENNAS)-1:0] wr_ant,
  input  td_int_t                       wr_int,
  input  td_frt_t                       wr_frt,
  input  logic                          commit,
  input  logic                          frame_strb,
  input  logic                          err_clr,
  output td_int_t                       int_delay [N_ANTENNAS],
  output td_frt_t                       frt_delay [N_ANTENNAS],
  output logic                          time_reg_trigger,
  output logic                          busy,
  output logic                          range_err
);

  localparam int CW =
    $clog2(TRIG_LEN > HOLD_LEN ? TRIG_LEN : HOLD_LEN);

`ifdef JB_DFE_TD_STEP_LIMIT_EN
  localparam int STEP_LIM = MAX_STEP;
`else
  // Wider than any legal delay difference, so a
  // single TRIG always lands on the target.
  localparam int STEP_LIM = 64;
`endif

  td_state_e state_q, state_d;

  td_int_t sh_int   [N_ANTENNAS];
  td_frt_t sh_frt   [N_ANTENNAS];
  td_int_t tg_int   [N_ANTENNAS];
  td_frt_t tg_frt   [N_ANTENNAS];
  td_int_t step_int [N_ANTENNAS];

  logic [N_ANTENNAS-1:0] reach;
  logic [N_ANTENNAS-1:0] off_tgt;

  logic          tmr_load;
  logic          tmr_count;
  logic          tmr_done;
  logic [CW-1:0] tmr_val;

  logic    wr_ok;
  logic    wr_clamp;
  td_int_t wr_int_c;
  logic    take_commit;
  logic    drop_commit;
  logic    enter_trig;
  logic    err_set;

  assign wr_ok       = int'(wr_ant) < N_ANTENNAS;
  assign wr_int_c    = clamp_int(wr_int, INT_MAX);
  assign wr_clamp    = (wr_int_c != wr_int);
  assign take_commit = commit && (state_q == IDLE);
  assign drop_commit = commit && (state_q != IDLE);
  assign enter_trig  = frame_strb && (state_q == ARMED);
  assign err_set     = (wr_en && (!wr_ok || wr_clamp))
                     || drop_commit;

  assign time_reg_trigger = (state_q == TRIG);
  assign busy             = (state_q != IDLE);

  // Next applied value per antenna, limited to
  // STEP_LIM away from the current output.
  always_comb begin
    for (int i = 0; i < N_ANTENNAS; i++) begin
      if (int'(tg_int[i]) > int'(int_delay[i]) + STEP_LIM)
        step_int[i] =
          td_int_t'(int'(int_delay[i]) + STEP_LIM);
      else if (int'(tg_int[i]) <
               int'(int_delay[i]) - STEP_LIM)
        step_int[i] =
          td_int_t'(int'(int_delay[i]) - STEP_LIM);
      else
        step_int[i] = tg_int[i];
      reach[i]   = (step_int[i] == tg_int[i]);
      off_tgt[i] = (int_delay[i] != tg_int[i]);
    end
  end

  always_comb begin
    state_d   = state_q;
    tmr_load  = 1'b0;
    tmr_count = 1'b0;
    tmr_val   = '0;
    unique case (state_q)
      IDLE: begin
        // A strobe in the commit cycle is ignored:
        // the update waits for the next boundary.
        if (commit)
          state_d = ARMED;
      end
      ARMED: begin
        if (frame_strb) begin
          state_d  = TRIG;
          tmr_load = 1'b1;
          tmr_val  = CW'(TRIG_LEN - 1);
        end
      end
      TRIG: begin
        tmr_count = 1'b1;
        if (tmr_done) begin
          state_d  = HOLD;
          tmr_load = 1'b1;
          tmr_val  = CW'(HOLD_LEN - 1);
        end
      end
      HOLD: begin
        tmr_count = 1'b1;
        if (tmr_done)
          state_d = (|off_tgt) ? ARMED : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  jb_dfe_td_pulse_timer #(
    .W(CW)
  ) u_timer (
    .clk_1x   (clk_1x),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .count    (tmr_count),
    .done     (tmr_done)
  );

  always_ff @(posedge clk_1x or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      range_err <= 1'b0;
      for (int i = 0; i < N_ANTENNAS; i++) begin
        sh_int[i]    <= '0;
        sh_frt[i]    <= '0;
        tg_int[i]    <= '0;
        tg_frt[i]    <= '0;
        int_delay[i] <= '0;
        frt_delay[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      if (err_set)
        range_err <= 1'b1;
      else if (err_clr)
        range_err <= 1'b0;
      for (int i = 0; i < N_ANTENNAS; i++) begin
        if (wr_en && wr_ok && int'(wr_ant) == i) begin
          sh_int[i] <= wr_int_c;
          sh_frt[i] <= wr_frt;
        end
        if (take_commit) begin
          tg_int[i] <= sh_int[i];
          tg_frt[i] <= sh_frt[i];
        end
        if (enter_trig) begin
          int_delay[i] <= step_int[i];
          if (reach[i])
            frt_delay[i] <= tg_frt[i];
        end
      end
    end
  end

endmodule
